// File: rtl/seg_pkg.sv
// Shared types and defaults for the serial segment-display driver.
package seg_pkg;

    localparam int SEG_BITS      = 64;
    localparam int CLK_DIV_DEF   = 4;
    localparam int FLASH_DIV_DEF = 25_000_000;
    localparam int REFRESH_DEF   = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_DONE
    } seg_state_e;

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running blink-phase generator and periodic refresh-request tick.
module seg_tick_gen
    import seg_pkg::*;
#(
    parameter int FLASH_DIV = FLASH_DIV_DEF,
    parameter int REFRESH   = REFRESH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_flash,
    output logic o_refresh_tick
);

    localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [FLASH_W-1:0] r_flash_cnt;
    logic               r_flash;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash_cnt <= '0;
            r_flash     <= 1'b0;
        end else if (r_flash_cnt == FLASH_W'(FLASH_DIV - 1)) begin
            r_flash_cnt <= '0;
            r_flash     <= ~r_flash;
        end else begin
            r_flash_cnt <= r_flash_cnt + 1'b1;
        end
    end

    assign o_flash = r_flash;

    if (REFRESH > 0) begin : g_refresh
        localparam int REF_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;

        logic [REF_W-1:0] r_ref_cnt;
        logic             w_ref_last;

        assign w_ref_last = (r_ref_cnt == REF_W'(REFRESH - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_ref_cnt <= '0;
            else        r_ref_cnt <= w_ref_last ? '0 : r_ref_cnt + 1'b1;
        end

        assign o_refresh_tick = w_ref_last;
    end else begin : g_no_refresh
        assign o_refresh_tick = 1'b0;
    end

endmodule

// File: rtl/seg_shift_ctrl.sv
// Shifts a 64-bit segment pattern MSB-first into a 74HC595-style chain, then latches it.
module seg_shift_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int FLASH_DIV = FLASH_DIV_DEF,
    parameter int REFRESH   = REFRESH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEG_BITS-1:0] seg_txt,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                flash,
    output logic                seg_clk,
    output logic                seg_dat,
    output logic                seg_lat,
    output logic                seg_clr_n
);

    localparam int         CNT_W    = $clog2(SEG_BITS);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    seg_state_e          r_state, w_state_nxt;
    logic [SEG_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [7:0]          r_div;
    logic                r_pending;
    logic                r_clr_n;
    logic                w_tick, w_trigger, w_accept, w_div_last, w_timed;

    seg_tick_gen #(
        .FLASH_DIV (FLASH_DIV),
        .REFRESH   (REFRESH)
    ) u_tick_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_flash        (flash),
        .o_refresh_tick (w_tick)
    );

    assign w_trigger  = start | r_pending | w_tick;
    assign w_accept   = (r_state == ST_IDLE) && w_trigger;
    assign w_timed    = r_state inside {ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH};
    assign w_div_last = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:     if (w_trigger)  w_state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_div_last) w_state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: if (w_div_last) w_state_nxt = (r_bit_cnt != '0) ? ST_SHIFT_LO : ST_LATCH;
            ST_LATCH:    if (w_div_last) w_state_nxt = ST_DONE;
            ST_DONE:                     w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        seg_clk   = (r_state == ST_SHIFT_HI);
        seg_lat   = (r_state == ST_LATCH);
        seg_dat   = (r_state inside {ST_SHIFT_LO, ST_SHIFT_HI}) && r_shreg[SEG_BITS-1];
        seg_clr_n = r_clr_n;
    end

    // Every timed state exits on w_div_last, so the divider is always zero on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_div <= '0;
        else if (w_timed && !w_div_last) r_div <= r_div + 1'b1;
        else                             r_div <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shreg   <= seg_txt;
            r_bit_cnt <= CNT_W'(SEG_BITS - 1);
        end else if (r_state == ST_SHIFT_HI && w_div_last) begin
            r_shreg <= {r_shreg[SEG_BITS-2:0], 1'b0};
            if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    // Requests arriving mid-transfer are remembered once and replayed from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_pending <= 1'b0;
        else if (r_state == ST_IDLE) r_pending <= 1'b0;
        else if (start || w_tick)    r_pending <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_clr_n <= 1'b0;
        else        r_clr_n <= 1'b1;
    end

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Directed bench for seg_shift_ctrl: data order, latency, pending replay, abort, blink, refresh.
module tb_seg_shift_ctrl;

    localparam logic [63:0] V1     = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] V_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_r;
    logic [63:0] seg_txt;
    logic        start, start_r;
    logic        busy, done, flash, seg_clk, seg_dat, seg_lat, seg_clr_n;
    logic        busy_r, done_r, flash_r, seg_clk_r, seg_dat_r, seg_lat_r, seg_clr_n_r;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg_shift_ctrl #(.CLK_DIV(2), .FLASH_DIV(8), .REFRESH(0)) dut (
        .clk(clk), .rst_n(rst_n), .seg_txt(seg_txt), .start(start),
        .busy(busy), .done(done), .flash(flash), .seg_clk(seg_clk),
        .seg_dat(seg_dat), .seg_lat(seg_lat), .seg_clr_n(seg_clr_n)
    );

    seg_shift_ctrl #(.CLK_DIV(2), .FLASH_DIV(8), .REFRESH(600)) dut_r (
        .clk(clk), .rst_n(rst_n_r), .seg_txt(V1), .start(start_r),
        .busy(busy_r), .done(done_r), .flash(flash_r), .seg_clk(seg_clk_r),
        .seg_dat(seg_dat_r), .seg_lat(seg_lat_r), .seg_clr_n(seg_clr_n_r)
    );

    // Posedge counter; read only at negedges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: shift seg_dat in on every seg_clk rise.
    logic [63:0] rx = '0;
    int          rise_cnt = 0;
    always @(posedge seg_clk) begin
        rx = {rx[62:0], seg_dat};
        rise_cnt++;
    end

    int   lat_pulses = 0, lat_cycles = 0;
    logic lat_prev = 1'b0;
    int   rise_at[4];
    int   n_rise = 0, n_done_r = 0;
    logic busy_r_prev = 1'b0;
    always @(negedge clk) begin
        if (seg_lat) lat_cycles++;
        if (seg_lat && !lat_prev) lat_pulses++;
        lat_prev = seg_lat;
        if (busy_r && !busy_r_prev) begin
            if (n_rise < 4) rise_at[n_rise] = cyc;
            n_rise++;
        end
        busy_r_prev = busy_r;
        if (done_r) n_done_r++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns the negedge cycle number where done is seen, or -1 on timeout.
    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
    endtask

    // One-cycle start pulse; returns the number of the accepting edge.
    task automatic pulse_start(input logic [63:0] txt, output int acc);
        seg_txt = txt;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
    endtask

    int base, acc, t_done, r0, lp0, lc0, cnt, toggles, bad;
    logic flash_prev;

    initial begin
        rst_n = 1'b0; rst_n_r = 1'b0;
        start = 1'b0; start_r = 1'b0;
        seg_txt = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, flash, seg_clk, seg_dat, seg_lat, seg_clr_n}, 0);
        rst_n = 1'b1; rst_n_r = 1'b1;
        base = cyc;
        @(negedge clk);
        check("clr_n_after_release", seg_clr_n, 1);
        check("idle_after_release", busy, 0);

        // Single transfer: order, latency (done sampled at the edge ending DONE), latch width.
        r0 = rise_cnt; lp0 = lat_pulses; lc0 = lat_cycles;
        pulse_start(V1, acc);
        check("a_busy_on_accept", busy, 1);
        wait_done(t_done);
        check("a_latency", t_done - acc + 1, 259);
        check("a_data", rx, V1);
        check("a_rises", rise_cnt - r0, 64);
        check("a_lat_pulses", lat_pulses - lp0, 1);
        check("a_lat_cycles", lat_cycles - lc0, 2);
        @(negedge clk);
        check("a_done_one_cycle", done, 0);
        check("a_idle_after", busy, 0);

        // Start while busy plus changed seg_txt: first transfer intact, second is all-ones.
        r0 = rise_cnt;
        pulse_start(V1, acc);
        repeat (130) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        seg_txt = V_ONES;
        check("b_busy_mid", busy, 1);
        wait_done(t_done);
        check("b_first_latency", t_done - acc + 1, 259);
        check("b_first_data", rx, V1);
        check("b_first_rises", rise_cnt - r0, 64);
        @(negedge clk);
        check("b_idle_gap", busy, 0);
        r0 = rise_cnt;
        @(negedge clk);
        check("b_restart", busy, 1);
        wait_done(t_done);
        check("b_second_data", rx, V_ONES);
        check("b_second_rises", rise_cnt - r0, 64);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("b_no_third", cnt, 0);

        // Reset at bit 30: async return to reset values, no latch, no restart; then blink.
        r0 = rise_cnt; lp0 = lat_pulses;
        pulse_start(V1, acc);
        for (int i = 0; i < 200 && (rise_cnt - r0) < 30; i++) @(negedge clk);
        check("c_reached_bit30", rise_cnt - r0, 30);
        #2 rst_n = 1'b0;
        #1 check("c_async_reset", {busy, done, flash, seg_clk, seg_dat, seg_lat, seg_clr_n}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0; toggles = 0; bad = 0;
        flash_prev = flash;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (busy || !seg_clr_n) cnt++;
            if (i <= 64 && flash != flash_prev) begin
                toggles++;
                if (i % 8 != 0) bad++;
            end
            flash_prev = flash;
        end
        check("c_busy_or_clr_low", cnt, 0);
        check("c_no_latch", lat_pulses - lp0, 0);
        check("d_flash_toggles", toggles, 8);
        check("d_flash_spacing", bad, 0);

        // Refresh instance: ticks at 600 and 1200; start coinciding with the 1800 tick.
        while (cyc < base + 1799) @(negedge clk);
        check("e_sync", cyc - base, 1799);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        while (cyc < base + 2300) @(negedge clk);
        check("e_transfers", n_rise, 3);
        check("e_done_pulses", n_done_r, 3);
        check("e_t600_in_window", (rise_at[0] - base >= 599) && (rise_at[0] - base <= 601), 1);
        check("e_t1200_in_window", (rise_at[1] - base >= 1199) && (rise_at[1] - base <= 1201), 1);
        check("e_t1800_in_window", (rise_at[2] - base >= 1799) && (rise_at[2] - base <= 1801), 1);
        check("e_idle_end", busy_r, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_shift_ctrl.md
SEG_SHIFT_CTRL -- requirements
Module: seg_shift_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per seg_clk half-period, legal range 1..255.
REQ-002 Parameter FLASH_DIV, default 25_000_000: clk cycles per flash half-period.
REQ-003 Parameter REFRESH, default 1_000_000: clk cycles between automatic refresh requests; a value of 0 disables automatic refresh.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 seg_txt  in  64  8-digit active-low segment pattern from the hex-to-segment converter.
REQ-007 start  in  1  request to transfer the current seg_txt to the display chain.
REQ-008 busy  out  1  transfer in progress.
REQ-009 done  out  1  one-cycle pulse when a transfer completes.
REQ-010 flash  out  1  blink phase fed back to the converter's flash input.
REQ-011 seg_clk  out  1  shift clock to the 74HC595-style chain.
REQ-012 seg_dat  out  1  serial data to the chain.
REQ-013 seg_lat  out  1  storage-register latch to the chain.
REQ-014 seg_clr_n  out  1  chain clear, active-low.

Function
REQ-015 FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-016 In IDLE, a trigger (start=1, or pending=1, or refresh tick) SHALL capture seg_txt into a 64-bit shift register, load bit count 63, and enter SHIFT_LO on the next edge.
REQ-017 busy SHALL be 1 in every state except IDLE; busy rises on the edge that accepts the trigger.
REQ-018 SHIFT_LO: seg_clk=0 and seg_dat=shreg[63] for CLK_DIV cycles, then go to SHIFT_HI.
REQ-019 SHIFT_HI: seg_clk=1 with seg_dat held for CLK_DIV cycles; on exit, shift shreg left by one; go to SHIFT_LO if count>0 (decrementing count), otherwise go to LATCH.
REQ-020 Bit order SHALL be MSB first (bit 63 first), giving exactly 64 seg_clk rising edges per transfer.
REQ-021 LATCH: seg_clk=0 and seg_lat=1 for CLK_DIV cycles, then go to DONE.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE; start-to-done latency SHALL be 2*64*CLK_DIV + CLK_DIV + 1 cycles after the accepting edge.
REQ-023 A start asserted while busy SHALL set a pending flag; the capture SHALL NOT be disturbed.
REQ-024 On return to IDLE with pending=1, a new transfer SHALL start immediately using seg_txt as sampled at that edge, and pending SHALL clear.
REQ-025 The refresh counter SHALL count free-running; on reaching REFRESH-1 it wraps to 0 and raises a tick that behaves like start (it sets pending if busy).
REQ-026 Simultaneous start and refresh tick SHALL produce a single transfer.
REQ-027 The flash counter SHALL wrap at FLASH_DIV-1 and toggle flash on the wrap, independent of the FSM.
REQ-028 seg_clr_n SHALL be 1 at all times after reset is released.

Reset
REQ-029 While rst_n=0: state=IDLE, shreg=0, counters=0, pending=0, busy=0, done=0, flash=0, seg_clk=0, seg_dat=0, seg_lat=0, seg_clr_n=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer immediately with no latch pulse; no transfer starts until a new trigger arrives after release.

Structure
REQ-031 Package seg_pkg SHALL hold the state enum, SEG_BITS=64, and the default CLK_DIV/FLASH_DIV/REFRESH constants.
REQ-032 The flash and refresh counters SHALL be implemented in one sub-module, seg_tick_gen, instantiated once.

Verification (CLK_DIV=2, FLASH_DIV=8, REFRESH=0 unless stated)
REQ-033 Stimulus: seg_txt=64'h0123_4567_89AB_CDEF, one-cycle start. Required: seg_dat sampled at the 64 seg_clk rises reconstructs the value; one seg_lat pulse of 2 cycles; done exactly 259 cycles after the accepting edge.
REQ-034 Stimulus: start pulsed at mid-shift, and seg_txt changed to 64'hFFFF_FFFF_FFFF_FFFF before done. Required: the first transfer is unchanged; a second transfer of all-ones begins on the edge after done.
REQ-035 Stimulus: rst_n low at bit 30. Required: all outputs return to reset values asynchronously; no seg_lat pulse; busy stays 0 after release.
REQ-036 Stimulus: free run for 64 cycles. Required: flash toggles every 8 cycles (4 full periods); seg_clr_n=1 throughout.
REQ-037 Stimulus: REFRESH=600, no start. Required: transfers begin at cycles 600 and 1200 (±1); a start coinciding with a tick yields one transfer.
